hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the decode-stage stall unit of the 5-stage MIPS pipeline.
- Replaces per-instruction-class IR decoding with a per-register Tnew countdown scoreboard and a cycle-accurate mult/div latency counter.
- Sits beside the D stage and drives PC, IF/ID and ID/EX control.
- The decoder supplies Tuse/Tnew per instruction. The block compares these against live countdowns and stalls only as long as needed.

Parameters:
- NREG, 32, architectural register count; register 0 is never tracked.
- RW, 5, register index width (log2 NREG).
- CW, 2, width of the Tnew/Tuse fields and of each scoreboard counter.
- MUL_CYC, 5, cycles HI/LO stay busy after a mult/multu issues.
- DIV_CYC, 10, cycles HI/LO stay busy after a div/divu issues.
- FWD_EN, 1, mode select.
  - 1: bypass network present; a consumer may issue when cnt ≤ Tuse.
  - 0: no bypass; a consumer waits until cnt = 0, which means the value is in the register file.
- SCW, 32, width of the stall performance counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- d_valid  in  1  D stage holds a real instruction (0 = bubble or flushed slot).
- d_rs  in  RW  source register A.
- d_rt  in  RW  source register B.
- d_use_rs  in  1  instruction reads rs.
- d_use_rt  in  1  instruction reads rt.
- d_tuse_rs  in  CW  cycles from D until rs is consumed (0 = branch/jr in D, 1 = ALU in E, 2 = store data in M).
- d_tuse_rt  in  CW  same as d_tuse_rs, for rt.
- d_we  in  1  instruction writes a GPR.
- d_rd  in  RW  destination register, already resolved (rd/rt/31).
- d_tnew  in  CW  cycles after issue until the result is forwardable (ALU 1, load 2).
- d_md_start  in  1  instruction is mult/multu/div/divu.
- d_md_div  in  1  with d_md_start: 1 = div, 0 = mult.
- d_md_use  in  1  instruction is mfhi/mflo/mthi/mtlo/mult/div, i.e. needs HI/LO free.
- stall  out  1  combinational hazard indication.
- pc_en  out  1  equal to !stall.
- ifid_en  out  1  equal to !stall.
- idex_clr  out  1  equal to stall; inserts a bubble into E.
- md_busy  out  1  HI/LO counter nonzero.
- stall_cycles  out  SCW  saturating count of stalled cycles.

Behaviour:
- State:
  - cnt[1..NREG-1], each CW bits.
  - md_cnt, wide enough for max(MUL_CYC, DIV_CYC).
  - stall_cycles.
- Reset:
  - rst_n low clears all state asynchronously to 0.
  - Outputs during and after reset: stall=0, pc_en=1, ifid_en=1, idex_clr=0, md_busy=0, stall_cycles=0.
- Issue condition: issue = d_valid & !stall.
- Hazard terms (all combinational, from current state and D inputs):
  - rs hazard = d_valid & d_use_rs & (d_rs≠0) & (FWD_EN ? cnt[d_rs] > d_tuse_rs : cnt[d_rs] ≠ 0).
  - rt hazard: same form with d_rt and d_tuse_rt.
  - md hazard = d_valid & d_md_use & (md_cnt ≠ 0).
  - stall = OR of the three terms.
- Scoreboard update, every clock edge:
  - Every nonzero cnt decrements by 1. Older instructions keep advancing during a stall.
  - If issue & d_we & d_rd≠0, then cnt[d_rd] ← d_tnew.
  - If the load and the decrement target the same register, the load wins.
  - d_tnew=0 clears the entry.
  - Counters never wrap: a counter at 0 stays at 0.
- HI/LO counter update:
  - If issue & d_md_start: md_cnt ← d_md_div ? DIV_CYC : MUL_CYC.
  - Otherwise, if md_cnt ≠ 0: md_cnt ← md_cnt − 1.
  - Consequence: an instruction with d_md_use in the cycle right after a mult/div issue sees md_cnt ≠ 0 and stalls.
- Back-to-back mult/div:
  - The second one stalls until md_cnt = 0.
  - It then reloads md_cnt with its own latency.
- stall_cycles: increments on every stalled cycle and saturates at all-ones.
- Bubble or flushed D (d_valid=0):
  - No stall and no scoreboard load.
  - Decrements still happen.
- Latency: stall is zero-cycle combinational; the scoreboard reflects an issue one edge later.
- Reset mid-operation: all pending entries are discarded; after release no stall occurs until a new producer issues.

Decomposition:
- Shared package holds:
  - Tuse/Tnew encodings: TUSE_D=0, TUSE_E=1, TUSE_M=2; TNEW_ALU=1, TNEW_LOAD=2.
  - Default MUL_CYC and DIV_CYC.
  - CW and RW.
- One natural sub-module, sb_counter: a single CW-bit load/decrement-to-zero cell, instantiated NREG−1 times via generate.
- The md counter and the hazard compare stay inline.

Test Plan:
- lw $3 (tnew 2), then addu $4,$3,$5 (tuse_rs 1) next cycle, FWD_EN=1:
  - exactly 1 stall cycle (cnt[3]=2>1, then 1≤1).
  - stall_cycles=1.
- ori $2 (tnew 1), then beq $2,$0 (tuse 0) immediately:
  - 1 stall cycle.
  - With FWD_EN=0: 1 stall for ori; 2 stalls for a preceding lw.
- div issued, then mflo in the next cycle:
  - stall held for 10 consecutive cycles, md_busy high for 10 cycles.
  - mflo issues on the 11th.
  - Same sequence with mult: 5 cycles.
- Producer writes $0, or consumer reads $0 (d_use_rs=1):
  - no stall.
  - cnt unchanged.
- lw $7 issued, then a lw $7 reissued while cnt[7]=1:
  - cnt[7] reloads to 2 (issue wins over decrement).
  - A dependent sw data read (tuse 2) never stalls.
- rst_n pulsed low asynchronously mid-divide with a pending load:
  - md_busy=0, stall=0, stall_cycles=0 immediately.
  - mflo right after release issues with no stall.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared encodings and default latencies for the decode-stage hazard scoreboard.
package hazard_scoreboard_pkg;

  localparam int unsigned CW = 2;
  localparam int unsigned RW = 5;

  localparam logic [CW-1:0] TUSE_D    = 2'd0;
  localparam logic [CW-1:0] TUSE_E    = 2'd1;
  localparam logic [CW-1:0] TUSE_M    = 2'd2;
  localparam logic [CW-1:0] TNEW_ALU  = 2'd1;
  localparam logic [CW-1:0] TNEW_LOAD = 2'd2;

  localparam int unsigned MUL_CYC_DEF = 5;
  localparam int unsigned DIV_CYC_DEF = 10;

endpackage

// File: rtl/hazard_scoreboard_sb_counter.sv
// One scoreboard entry: loads a Tnew value, otherwise counts down and holds at zero.
module sb_counter
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned W = hazard_scoreboard_pkg::CW
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  // A load from a newly issued producer takes priority over the decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage stall unit: per-register Tnew countdowns plus a HI/LO busy counter.
module hazard_scoreboard #(
  parameter int unsigned NREG    = 32,
  parameter int unsigned RW      = hazard_scoreboard_pkg::RW,
  parameter int unsigned CW      = hazard_scoreboard_pkg::CW,
  parameter int unsigned MUL_CYC = hazard_scoreboard_pkg::MUL_CYC_DEF,
  parameter int unsigned DIV_CYC = hazard_scoreboard_pkg::DIV_CYC_DEF,
  parameter bit          FWD_EN  = 1'b1,
  parameter int unsigned SCW     = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           d_valid,
  input  logic [RW-1:0]  d_rs,
  input  logic [RW-1:0]  d_rt,
  input  logic           d_use_rs,
  input  logic           d_use_rt,
  input  logic [CW-1:0]  d_tuse_rs,
  input  logic [CW-1:0]  d_tuse_rt,
  input  logic           d_we,
  input  logic [RW-1:0]  d_rd,
  input  logic [CW-1:0]  d_tnew,
  input  logic           d_md_start,
  input  logic           d_md_div,
  input  logic           d_md_use,
  output logic           stall,
  output logic           pc_en,
  output logic           ifid_en,
  output logic           idex_clr,
  output logic           md_busy,
  output logic [SCW-1:0] stall_cycles
);

  import hazard_scoreboard_pkg::*;

  localparam int unsigned MD_MAX = (MUL_CYC > DIV_CYC) ? MUL_CYC : DIV_CYC;
  localparam int unsigned MDW    = $clog2(MD_MAX + 1);

  logic [CW-1:0]  cnt [NREG];
  logic [CW-1:0]  cnt_rs, cnt_rt;
  logic           haz_rs, haz_rt, haz_md, issue;
  logic [MDW-1:0] md_cnt_q, md_cnt_d;
  logic [SCW-1:0] stall_cnt_q, stall_cnt_d;

  assign cnt[0] = '0;

  for (genvar i = 1; i < NREG; i++) begin : g_cnt
    logic ld;
    assign ld = issue & d_we & (d_rd == RW'(i));
    sb_counter #(.W(CW)) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (ld),
      .load_val (d_tnew),
      .cnt      (cnt[i])
    );
  end

  always_comb begin
    cnt_rs = cnt[d_rs];
    cnt_rt = cnt[d_rt];
    // With bypassing a consumer only waits until the value reaches its use stage.
    if (FWD_EN) begin
      haz_rs = d_valid & d_use_rs & (d_rs != '0) & (cnt_rs > d_tuse_rs);
      haz_rt = d_valid & d_use_rt & (d_rt != '0) & (cnt_rt > d_tuse_rt);
    end else begin
      haz_rs = d_valid & d_use_rs & (d_rs != '0) & (cnt_rs != '0);
      haz_rt = d_valid & d_use_rt & (d_rt != '0) & (cnt_rt != '0);
    end
    haz_md = d_valid & d_md_use & (md_cnt_q != '0);
    stall  = haz_rs | haz_rt | haz_md;
    issue  = d_valid & ~stall;
  end

  always_comb begin
    md_cnt_d = md_cnt_q;
    if (issue && d_md_start) begin
      md_cnt_d = d_md_div ? MDW'(DIV_CYC) : MDW'(MUL_CYC);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - MDW'(1);
    end
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + SCW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign pc_en        = ~stall;
  assign ifid_en      = ~stall;
  assign idex_clr     = stall;
  assign md_busy      = (md_cnt_q != '0);
  assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: cycle-by-cycle vector table plus hand sequences for mult/div, reset and no-bypass mode.
module tb_hazard_scoreboard;

  logic        clk, rst_n;
  logic        d_valid, d_use_rs, d_use_rt, d_we, d_md_start, d_md_div, d_md_use;
  logic [4:0]  d_rs, d_rt, d_rd;
  logic [1:0]  d_tuse_rs, d_tuse_rt, d_tnew;
  logic        stall, pc_en, ifid_en, idex_clr, md_busy;
  logic [31:0] stall_cycles;
  logic        nf_stall, nf_pc_en, nf_ifid_en, nf_idex_clr, nf_md_busy;
  logic [31:0] nf_stall_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_scoreboard #(.FWD_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
    .d_use_rs(d_use_rs), .d_use_rt(d_use_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_we(d_we), .d_rd(d_rd), .d_tnew(d_tnew), .d_md_start(d_md_start), .d_md_div(d_md_div),
    .d_md_use(d_md_use), .stall(stall), .pc_en(pc_en), .ifid_en(ifid_en),
    .idex_clr(idex_clr), .md_busy(md_busy), .stall_cycles(stall_cycles)
  );

  hazard_scoreboard #(.FWD_EN(1'b0)) dut_nf (
    .clk(clk), .rst_n(rst_n), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
    .d_use_rs(d_use_rs), .d_use_rt(d_use_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_we(d_we), .d_rd(d_rd), .d_tnew(d_tnew), .d_md_start(d_md_start), .d_md_div(d_md_div),
    .d_md_use(d_md_use), .stall(nf_stall), .pc_en(nf_pc_en), .ifid_en(nf_ifid_en),
    .idex_clr(nf_idex_clr), .md_busy(nf_md_busy), .stall_cycles(nf_stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        valid;
    logic [4:0]  rs;
    logic        use_rs;
    logic [1:0]  tuse_rs;
    logic [4:0]  rt;
    logic        use_rt;
    logic [1:0]  tuse_rt;
    logic        we;
    logic [4:0]  rd;
    logic [1:0]  tnew;
    logic        md_start;
    logic        md_div;
    logic        md_use;
    logic        exp_stall;
    logic        exp_busy;
    logic [31:0] exp_sc;
  } vec_t;

  function automatic vec_t mk(string nm, int valid, int rs, int urs, int trs, int rt, int urt,
                              int trt, int we, int rd, int tnew, int mds, int mdd, int mdu,
                              int es, int eb, int esc);
    vec_t v;
    v.name      = nm;
    v.valid     = (valid != 0);
    v.rs        = 5'(rs);
    v.use_rs    = (urs != 0);
    v.tuse_rs   = 2'(trs);
    v.rt        = 5'(rt);
    v.use_rt    = (urt != 0);
    v.tuse_rt   = 2'(trt);
    v.we        = (we != 0);
    v.rd        = 5'(rd);
    v.tnew      = 2'(tnew);
    v.md_start  = (mds != 0);
    v.md_div    = (mdd != 0);
    v.md_use    = (mdu != 0);
    v.exp_stall = (es != 0);
    v.exp_busy  = (eb != 0);
    v.exp_sc    = 32'(esc);
    return v;
  endfunction

  task automatic drive(input vec_t v);
    d_valid = v.valid;   d_rs = v.rs;   d_use_rs = v.use_rs;   d_tuse_rs = v.tuse_rs;
    d_rt = v.rt;         d_use_rt = v.use_rt;                  d_tuse_rt = v.tuse_rt;
    d_we = v.we;         d_rd = v.rd;   d_tnew = v.tnew;
    d_md_start = v.md_start; d_md_div = v.md_div; d_md_use = v.md_use;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles the given DUT stalls on the currently driven instruction, bounded.
  task automatic count_stalls(input bit nf, input int bound, output int ns, output int nb);
    ns = 0;
    nb = 0;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if ((nf ? nf_md_busy : md_busy) === 1'b1) nb++;
      if ((nf ? nf_stall : stall) !== 1'b1) break;
      ns++;
      step();
    end
    step();
  endtask

  vec_t tbl[19];
  vec_t nop, mflo, div_i, mult_i;
  int   ns, nb;

  initial begin
    nop    = mk("nop",  0, 0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0);
    mflo   = mk("mflo", 1, 0,0,0, 0,0,0, 1,8,1, 0,0,1, 0,0,0);
    div_i  = mk("div",  1, 0,0,0, 0,0,0, 0,0,0, 1,1,1, 0,0,0);
    mult_i = mk("mult", 1, 0,0,0, 0,0,0, 0,0,0, 1,0,1, 0,0,0);

    //                 name        v  rs u  t  rt u  t  we rd tn ms md mu  es eb sc
    tbl[0]  = mk("lw3",        1, 0,0,0, 0,0,0, 1,3,2, 0,0,0, 0,0,0);
    tbl[1]  = mk("addu_stall", 1, 3,1,1, 5,1,1, 1,4,1, 0,0,0, 1,0,0);
    tbl[2]  = mk("addu_go",    1, 3,1,1, 5,1,1, 1,4,1, 0,0,0, 0,0,1);
    tbl[3]  = mk("ori2",       1, 0,1,1, 0,0,0, 1,2,1, 0,0,0, 0,0,1);
    tbl[4]  = mk("beq2_stall", 1, 2,1,0, 0,1,0, 0,0,0, 0,0,0, 1,0,1);
    tbl[5]  = mk("beq2_go",    1, 2,1,0, 0,1,0, 0,0,0, 0,0,0, 0,0,2);
    tbl[6]  = mk("write_r0",   1, 0,0,0, 0,0,0, 1,0,2, 0,0,0, 0,0,2);
    tbl[7]  = mk("read_r0",    1, 0,1,0, 0,1,0, 0,0,0, 0,0,0, 0,0,2);
    tbl[8]  = mk("lw9",        1, 0,0,0, 0,0,0, 1,9,2, 0,0,0, 0,0,2);
    tbl[9]  = mk("bubble",     0, 9,1,0, 0,0,0, 1,10,2,0,0,0, 0,0,2);
    tbl[10] = mk("read_r10",   1, 10,1,0,0,0,0, 0,0,0, 0,0,0, 0,0,2);
    tbl[11] = mk("lw7a",       1, 0,0,0, 0,0,0, 1,7,2, 0,0,0, 0,0,2);
    tbl[12] = mk("nop",        0, 0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,2);
    tbl[13] = mk("lw7b",       1, 0,0,0, 0,0,0, 1,7,2, 0,0,0, 0,0,2);
    tbl[14] = mk("beq7_s1",    1, 7,1,0, 0,0,0, 0,0,0, 0,0,0, 1,0,2);
    tbl[15] = mk("beq7_s2",    1, 7,1,0, 0,0,0, 0,0,0, 0,0,0, 1,0,3);
    tbl[16] = mk("beq7_go",    1, 7,1,0, 0,0,0, 0,0,0, 0,0,0, 0,0,4);
    tbl[17] = mk("lw7c",       1, 0,0,0, 0,0,0, 1,7,2, 0,0,0, 0,0,4);
    tbl[18] = mk("sw7",        1, 29,1,1,7,1,2, 0,0,0, 0,0,0, 0,0,4);

    rst_n = 1'b0;
    drive(nop);
    #2;
    check("rst_stall",    32'(stall), 32'd0);
    check("rst_pc_en",    32'(pc_en), 32'd1);
    check("rst_ifid_en",  32'(ifid_en), 32'd1);
    check("rst_idex_clr", 32'(idex_clr), 32'd0);
    check("rst_md_busy",  32'(md_busy), 32'd0);
    check("rst_sc",       stall_cycles, 32'd0);
    #10 rst_n = 1'b1;
    step();

    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(negedge clk);
      check({tbl[i].name, "_stall"}, 32'(stall), 32'(tbl[i].exp_stall));
      check({tbl[i].name, "_pc_en"}, 32'(pc_en), 32'(!tbl[i].exp_stall));
      check({tbl[i].name, "_ifid"},  32'(ifid_en), 32'(!tbl[i].exp_stall));
      check({tbl[i].name, "_idex"},  32'(idex_clr), 32'(tbl[i].exp_stall));
      check({tbl[i].name, "_busy"},  32'(md_busy), 32'(tbl[i].exp_busy));
      check({tbl[i].name, "_sc"},    stall_cycles, tbl[i].exp_sc);
      step();
    end

    // div then mflo: 10 stalled cycles, mflo issues on the 11th
    drive(div_i);
    @(negedge clk);
    check("div_issue", 32'(stall), 32'd0);
    step();
    drive(mflo);
    count_stalls(1'b0, 20, ns, nb);
    check("div_mflo_stalls", 32'(ns), 32'd10);
    check("div_busy_cycles", 32'(nb), 32'd10);
    drive(nop);

    drive(mult_i);
    step();
    drive(mflo);
    count_stalls(1'b0, 20, ns, nb);
    check("mult_mflo_stalls", 32'(ns), 32'd5);
    check("mult_busy_cycles", 32'(nb), 32'd5);
    drive(nop);
    @(negedge clk);
    check("sc_after_md", stall_cycles, 32'd19);
    step();

    // div followed by mult: mult waits out the divide, then reloads with its own latency
    drive(div_i);
    step();
    drive(mult_i);
    count_stalls(1'b0, 20, ns, nb);
    check("b2b_mult_stalls", 32'(ns), 32'd10);
    drive(nop);
    nb = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (md_busy !== 1'b1) break;
      nb++;
      step();
    end
    check("b2b_mult_busy", 32'(nb), 32'd5);
    check("sc_after_b2b", stall_cycles, 32'd29);
    step();

    // asynchronous reset in the middle of a divide with a load pending
    drive(mk("lw3r", 1, 0,0,0, 0,0,0, 1,3,2, 0,0,0, 0,0,0));
    step();
    drive(div_i);
    step();
    drive(mk("mflo_rd3", 1, 3,1,0, 0,0,0, 0,0,0, 0,0,1, 0,0,0));
    #1;
    check("pre_rst_stall", 32'(stall), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_stall", 32'(stall), 32'd0);
    check("mid_rst_busy",  32'(md_busy), 32'd0);
    check("mid_rst_sc",    stall_cycles, 32'd0);
    #3 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_stall", 32'(stall), 32'd0);
    check("post_rst_busy",  32'(md_busy), 32'd0);
    step();

    // no-bypass instance: ori costs 1 stall, lw costs 2 for a branch reading it in D
    drive(mk("ori2nf", 1, 0,0,0, 0,0,0, 1,2,1, 0,0,0, 0,0,0));
    step();
    drive(mk("beq2nf", 1, 2,1,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0));
    count_stalls(1'b1, 8, ns, nb);
    check("nf_ori_beq_stalls", 32'(ns), 32'd1);
    drive(mk("lw2nf", 1, 0,0,0, 0,0,0, 1,2,2, 0,0,0, 0,0,0));
    step();
    drive(mk("beq2nf", 1, 2,1,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0));
    count_stalls(1'b1, 8, ns, nb);
    check("nf_lw_beq_stalls", 32'(ns), 32'd2);
    drive(mk("lw4nf", 1, 0,0,0, 0,0,0, 1,4,2, 0,0,0, 0,0,0));
    step();
    drive(mk("addu4nf", 1, 4,1,1, 0,0,0, 0,0,0, 0,0,0, 0,0,0));
    count_stalls(1'b1, 8, ns, nb);
    check("nf_lw_addu_stalls", 32'(ns), 32'd2);
    check("nf_sc", nf_stall_cycles, 32'd5);
    drive(nop);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
